core_input_loader: RTL and testbench
====================================

CORE_INPUT_LOADER -- requirements
Module: core_input_loader

Interface
REQ-001 SHALL have parameter LANES, default 8: number of activation lanes and of weight lanes.
REQ-002 SHALL have parameter DW, default 8: bits per lane element.
REQ-003 SHALL have parameter BW, default 32: input beat width; LANES*DW SHALL be an integer multiple of BW (default 2 beats per row).
REQ-004 SHALL have port clk, input, 1: the block's single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_data, input, BW: packed element beat.
REQ-007 SHALL have port in_valid, input, 1: in_data and in_sel valid.
REQ-008 SHALL have port in_sel, input, 1: 0 = activation beat, 1 = weight beat.
REQ-009 SHALL have port in_ready, output, 1: beat accepted when in_valid && in_ready.
REQ-010 SHALL have port ctrl_full, input, 1: downstream input controller cannot take a write.
REQ-011 SHALL have port ainport, output, unpacked [0:LANES-1] of DW: activation row to the controller.
REQ-012 SHALL have port winport, output, unpacked [0:LANES-1] of DW: weight row to the controller.
REQ-013 SHALL have port write, output, 1: one-cycle push of ainport/winport.
REQ-014 SHALL have port rows, output, 16: count of rows pushed.
REQ-015 SHALL have port sel_err, output, 1: sticky flag for a beat whose in_sel mismatches the expected type.

Function
REQ-016 SHALL implement FSM states FILL_A, FILL_W, ISSUE; reset state FILL_A.
REQ-017 SHALL assert in_ready in FILL_A and FILL_W only; in ISSUE in_ready SHALL be 0.
REQ-018 SHALL, in FILL_A, place accepted beat k (k = 0..BEATS-1) so byte b of in_data[8b+7:8b] goes to ainport[k*BW/DW + b].
REQ-019 SHALL fill winport identically in FILL_W.
REQ-020 SHALL move FILL_A->FILL_W on acceptance of the last activation beat, and FILL_W->ISSUE on the last weight beat.
REQ-021 SHALL discard an accepted beat whose in_sel does not match the state, without advancing the beat counter, and set sel_err.
REQ-022 SHALL, in ISSUE, assert write for exactly one cycle when ctrl_full=0, then go to FILL_A in the next cycle; with ctrl_full=1 it SHALL hold in ISSUE with write=0 and the row unchanged.
REQ-023 SHALL hold ainport/winport stable from ISSUE entry through the write cycle; at most one write per row.
REQ-024 SHALL increment rows on each write, wrapping 0xFFFF->0x0000.
REQ-025 SHALL give minimum latency of 1 cycle from the last weight beat to write, and a throughput of one row per 2*BEATS+1 cycles.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, force state FILL_A, beat counter 0, write=0, rows=0, sel_err=0, and all ainport/winport elements to 0.
REQ-027 SHALL drop any partial row on reset mid-fill or mid-ISSUE; no write SHALL issue in the reset cycle.
REQ-028 SHALL hold in_ready=0 while rst=1.

Structure
REQ-029 SHALL take LANES, DW and the state enum (FILL_A/FILL_W/ISSUE) from a shared package systola_pkg also used by core_input_ctrl.
REQ-030 SHALL derive BEATS = LANES*DW/BW as a localparam and size the beat counter as $clog2(BEATS) bits (min 1).
REQ-031 SHALL contain one sub-module, row_packer, instantiated twice (activation, weight): holds the row register and writes one beat at index k.

Verification
REQ-032 Beats A:0x04030201,0x08070605 then W:0x14131211,0x18171615, ctrl_full=0 -> one write with ainport=1..8, winport=0x11..0x18; rows=1.
REQ-033 Same row with ctrl_full=1 for 5 cycles after ISSUE entry -> write=0 and in_ready=0 for those 5 cycles, one write in the cycle after ctrl_full drops, outputs unchanged.
REQ-034 W beat sent in FILL_A -> beat dropped, sel_err=1 until rst; correct row sent next -> write with correct data.
REQ-035 rst pulsed after the first A beat -> no write; the next full 4-beat row yields ainport from fresh beats only; rows=1.
REQ-036 16 back-to-back rows, in_valid held 1 -> 16 writes, 5 cycles apart; rows=16.
REQ-037 rows preloaded to 0xFFFF by 65535 writes -> next write gives rows=0x0000.

Source files
------------

// File: rtl/systola_pkg.sv
// systola_pkg: shared lane geometry and loader/controller state encoding
package systola_pkg;
  localparam int SYS_LANES = 8;
  localparam int SYS_DW = 8;
  typedef enum logic [1:0] {FILL_A, FILL_W, ISSUE} state_t;
endpackage

// File: rtl/core_input_loader_row_packer.sv
// row_packer: row register that captures one input beat at beat index k
module row_packer #(
  parameter int LANES = 8,
  parameter int DW = 8,
  parameter int BW = 32,
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] k,
  input  logic [BW-1:0] data,
  output logic [DW-1:0] row [0:LANES-1]
);
  localparam int EPB = BW / DW;
  // each lane takes its element from the beat whose index covers it
  always_ff @(posedge clk)
    for (int l = 0; l < LANES; l++)
      if (rst) row[l] <= '0;
      else if (en && k == CW'(l / EPB)) row[l] <= data[(l % EPB) * DW +: DW];
endmodule

// File: rtl/core_input_loader.sv
// core_input_loader: assembles activation and weight rows from beats and pushes them downstream
module core_input_loader
  import systola_pkg::*;
#(
  parameter int LANES = SYS_LANES,
  parameter int DW = SYS_DW,
  parameter int BW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_sel,
  output logic          in_ready,
  input  logic          ctrl_full,
  output logic [DW-1:0] ainport [0:LANES-1],
  output logic [DW-1:0] winport [0:LANES-1],
  output logic          write,
  output logic [15:0]   rows,
  output logic          sel_err
);
  localparam int BEATS = LANES * DW / BW;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic acc, want, hit, last;
  assign in_ready = !rst && state != ISSUE;
  assign write = !rst && state == ISSUE && !ctrl_full;
  assign acc = in_valid && in_ready;
  assign want = state == FILL_W;
  assign hit = acc && in_sel == want;
  assign last = cnt == CW'(BEATS - 1);
  // advance beat index on matching beats; leave ISSUE once the row is pushed
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (hit) begin
      cnt_n = last ? '0 : cnt + CW'(1);
      state_n = !last ? state : want ? ISSUE : FILL_W;
    end
    if (write) state_n = FILL_A;
  end
  // state, beat index, row count and sticky type-mismatch flag
  always_ff @(posedge clk)
    if (rst) begin
      state <= FILL_A;
      cnt <= '0;
      rows <= '0;
      sel_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (write) rows <= rows + 16'd1;
      if (acc && in_sel != want) sel_err <= 1'b1;
    end
  row_packer #(.LANES(LANES), .DW(DW), .BW(BW), .CW(CW)) u_a (
    .clk(clk), .rst(rst), .en(hit && !want), .k(cnt), .data(in_data), .row(ainport)
  );
  row_packer #(.LANES(LANES), .DW(DW), .BW(BW), .CW(CW)) u_w (
    .clk(clk), .rst(rst), .en(hit && want), .k(cnt), .data(in_data), .row(winport)
  );
endmodule

// File: tb/tb_core_input_loader.sv
// tb_core_input_loader: directed table and sequence checks for core_input_loader
module tb_core_input_loader;
  import systola_pkg::*;
  logic clk = 0, rst, in_valid, in_sel, ctrl_full, in_ready, write, sel_err;
  logic [31:0] in_data;
  logic [7:0] ainport [0:7];
  logic [7:0] winport [0:7];
  logic [15:0] rows;
  int errors = 0, checks = 0, cyc = 0, wn = 0, rexp = 0;
  int wt [64];
  typedef struct {
    logic [31:0] a0, a1, w0, w1;
    logic [7:0] ea [8];
    logic [7:0] ew [8];
  } vec_t;
  vec_t tbl [3];

  core_input_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sel(in_sel),
    .in_ready(in_ready), .ctrl_full(ctrl_full), .ainport(ainport), .winport(winport),
    .write(write), .rows(rows), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (write) begin
      if (wn < 64) wt[wn] <= cyc;
      wn <= wn + 1;
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic beat(input logic s, input logic [31:0] d);
    @(negedge clk);
    in_valid = 1;
    in_sel = s;
    in_data = d;
  endtask

  task automatic row4(input vec_t v);
    beat(0, v.a0);
    beat(0, v.a1);
    beat(1, v.w0);
    beat(1, v.w1);
    @(negedge clk);
    in_valid = 0;
    #1;
  endtask

  task automatic chk_row(input vec_t v);
    for (int l = 0; l < 8; l++) begin
      chk($sformatf("ain%0d", l), 32'(ainport[l]), 32'(v.ea[l]));
      chk($sformatf("win%0d", l), 32'(winport[l]), 32'(v.ew[l]));
    end
  endtask

  task automatic after_write(input int w0);
    @(negedge clk);
    #1;
    rexp++;
    chk("rows", 32'(rows), rexp);
    chk("write_drop", 32'(write), 0);
    chk("ready_back", 32'(in_ready), 1);
    chk("one_write", wn - w0, 1);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1;
    in_valid = 0;
    ctrl_full = 0;
    #1;
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_write", 32'(write), 0);
    @(negedge clk);
    rst = 0;
    rexp = 0;
  endtask

  initial begin
    int w0, idx;
    bit rdy;
    logic [31:0] bd [64];
    logic bs [64];
    tbl[0].a0 = 32'h04030201; tbl[0].a1 = 32'h08070605;
    tbl[0].w0 = 32'h14131211; tbl[0].w1 = 32'h18171615;
    tbl[0].ea = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    tbl[0].ew = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    tbl[1].a0 = 32'hFFFFFFFF; tbl[1].a1 = 32'h00000000;
    tbl[1].w0 = 32'h00000000; tbl[1].w1 = 32'hFFFFFFFF;
    tbl[1].ea = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1].ew = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[2].a0 = 32'h12345678; tbl[2].a1 = 32'h9ABCDEF0;
    tbl[2].w0 = 32'hDEADBEEF; tbl[2].w1 = 32'hCAFEF00D;
    tbl[2].ea = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hF0, 8'hDE, 8'hBC, 8'h9A};
    tbl[2].ew = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    rst = 1; in_valid = 0; in_sel = 0; in_data = 0; ctrl_full = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_write", 32'(write), 0);
    rst = 0;
    @(negedge clk);
    #1;
    chk("init_rows", 32'(rows), 0);
    chk("init_sel_err", 32'(sel_err), 0);
    chk("init_ain0", 32'(ainport[0]), 0);
    chk("init_win7", 32'(winport[7]), 0);
    chk("init_ready", 32'(in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      w0 = wn;
      row4(tbl[i]);
      chk("issue_write", 32'(write), 1);
      chk("issue_ready", 32'(in_ready), 0);
      chk_row(tbl[i]);
      after_write(w0);
    end
    ctrl_full = 1;
    w0 = wn;
    row4(tbl[0]);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      chk("full_write", 32'(write), 0);
      chk("full_ready", 32'(in_ready), 0);
    end
    @(negedge clk);
    ctrl_full = 0;
    #1;
    chk("full_release_write", 32'(write), 1);
    chk("full_no_early", wn - w0, 0);
    chk_row(tbl[0]);
    after_write(w0);
    ctrl_full = 1;
    w0 = wn;
    row4(tbl[1]);
    @(negedge clk);
    rst = 1;
    ctrl_full = 0;
    #1;
    chk("rst_issue_write", 32'(write), 0);
    @(negedge clk);
    rst = 0;
    rexp = 0;
    #1;
    chk("rst_issue_nowr", wn - w0, 0);
    chk("rst_issue_rows", 32'(rows), 0);
    chk("rst_issue_ain", 32'(ainport[0]), 0);
    beat(0, 32'hAAAAAAAA);
    @(negedge clk);
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    w0 = wn;
    row4(tbl[2]);
    chk("midfill_write", 32'(write), 1);
    chk_row(tbl[2]);
    after_write(w0);
    beat(1, 32'h99999999);
    @(negedge clk);
    in_valid = 0;
    #1;
    chk("sel_err_set", 32'(sel_err), 1);
    chk("sel_ready", 32'(in_ready), 1);
    w0 = wn;
    row4(tbl[0]);
    chk("sel_write", 32'(write), 1);
    chk_row(tbl[0]);
    after_write(w0);
    chk("sel_err_sticky", 32'(sel_err), 1);
    do_reset();
    #1;
    chk("sel_err_clr", 32'(sel_err), 0);
    for (int r = 0; r < 16; r++)
      for (int j = 0; j < 4; j++) begin
        bs[r * 4 + j] = j >= 2;
        bd[r * 4 + j] = {8'(r), 8'(j), 8'h5A, 8'(r + j)};
      end
    idx = 0;
    w0 = wn;
    for (int c = 0; c < 200 && (wn - w0) < 16; c++) begin
      @(negedge clk);
      if (idx < 64) begin
        in_valid = 1;
        in_sel = bs[idx];
        in_data = bd[idx];
      end else in_valid = 0;
      rdy = in_ready;
      @(posedge clk);
      if (rdy && idx < 64) idx++;
    end
    @(negedge clk);
    in_valid = 0;
    #1;
    chk("b2b_count", wn - w0, 16);
    for (int i = 1; i < 16; i++) chk($sformatf("b2b_gap%0d", i), wt[w0 + i] - wt[w0 + i - 1], 5);
    chk("b2b_rows", 32'(rows), 16);
    chk("b2b_ain0", 32'(ainport[0]), 32'h0F);
    chk("b2b_ain5", 32'(ainport[5]), 32'h5A);
    chk("b2b_win4", 32'(winport[4]), 32'h12);
    chk("b2b_win7", 32'(winport[7]), 32'h0F);
    ctrl_full = 1;
    row4(tbl[1]);
    force dut.rows = 16'hFFFF;
    #1;
    release dut.rows;
    #1;
    chk("wrap_pre", 32'(rows), 32'hFFFF);
    @(negedge clk);
    ctrl_full = 0;
    #1;
    chk("wrap_write", 32'(write), 1);
    @(negedge clk);
    #1;
    chk("wrap_rows", 32'(rows), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
